ps2_rx_fifo: RTL and testbench

Parametrised PS/2 keyboard receiver for the calculator datapath. Synchronises and de-glitches the keyboard clock and data lines, deframes 11-bit PS/2 frames, checks odd parity and stop bit, and enforces a frame timeout. Valid scan codes go into a first-word-fall-through FIFO, optionally merged with their 0xF0 break prefix, so the key decoder can drain them at its own pace. It replaces the single-register keyboard front end.

---
 rtl/ps2_rx_fifo.sv | 184 ++++++++++++++++++
 tb/tb_ps2_rx_fifo.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: synchronise/filter kclk, deframe 11-bit frames,
// check parity/stop/timeout, merge 0xF0 break prefixes, buffer in a FWFT FIFO.
module ps2_rx_fifo #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned FILT      = 4,
    parameter int unsigned TIMEOUT   = 4096,
    parameter bit          MERGE_BRK = 1'b1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         kclk,
    input  logic                         kdata,
    input  logic                         rd_en,
    output logic [8:0]                   dout,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         busy,
    output logic                         parity_err,
    output logic                         frame_err,
    output logic                         overflow
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned FW = $clog2(FILT + 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PARITY, S_STOP} state_t;

    state_t          r_state, w_state_nxt;
    logic            r_kclk_s1, r_kclk_s2, r_kdat_s1, r_kdat_s2;
    logic            r_kclk_f, r_fall;
    logic [FW-1:0]   r_flt_cnt;
    logic [TW-1:0]   r_tmo_cnt;
    logic [7:0]      r_shift;
    logic [2:0]      r_bit_cnt;
    logic            r_par, r_brk_pend, r_busy;
    logic            r_parity_err, r_frame_err, r_overflow, r_empty;
    logic [8:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]   r_count, w_count_nxt;
    logic            w_tmo, w_valid, w_perr, w_ferr, w_push, w_full, w_pop, w_wr;
    logic            w_flt_hit;
    logic [8:0]      w_word;

    // Input synchronisers and kclk glitch filter; idle level is 1.
    assign w_flt_hit = (r_kclk_s2 != r_kclk_f) && (r_flt_cnt == FW'(FILT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_kclk_s1 <= 1'b1;
            r_kclk_s2 <= 1'b1;
            r_kdat_s1 <= 1'b1;
            r_kdat_s2 <= 1'b1;
            r_kclk_f  <= 1'b1;
            r_flt_cnt <= '0;
            r_fall    <= 1'b0;
        end else begin
            r_kclk_s1 <= kclk;
            r_kclk_s2 <= r_kclk_s1;
            r_kdat_s1 <= kdata;
            r_kdat_s2 <= r_kdat_s1;
            r_fall    <= w_flt_hit && !r_kclk_s2;
            if (r_kclk_s2 == r_kclk_f) begin
                r_flt_cnt <= '0;
            end else if (w_flt_hit) begin
                r_kclk_f  <= r_kclk_s2;
                r_flt_cnt <= '0;
            end else begin
                r_flt_cnt <= r_flt_cnt + FW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Frame FSM; timeout has priority over a coincident fall pulse.
    always_comb begin
        w_state_nxt = r_state;
        w_valid     = 1'b0;
        w_perr      = 1'b0;
        w_ferr      = 1'b0;
        w_tmo       = (r_state != S_IDLE) && (r_tmo_cnt == TW'(TIMEOUT));
        if (w_tmo) begin
            w_state_nxt = S_IDLE;
            w_ferr      = 1'b1;
        end else if (r_fall) begin
            case (r_state)
                S_IDLE:   if (!r_kdat_s2) w_state_nxt = S_SHIFT;
                S_SHIFT:  if (r_bit_cnt == 3'd7) w_state_nxt = S_PARITY;
                S_PARITY: w_state_nxt = S_STOP;
                S_STOP: begin
                    w_state_nxt = S_IDLE;
                    if (!(^{r_shift, r_par})) w_perr  = 1'b1;
                    else if (!r_kdat_s2)      w_ferr  = 1'b1;
                    else                      w_valid = 1'b1;
                end
                default:  w_state_nxt = S_IDLE;
            endcase
        end
    end

    assign w_push = w_valid && !(MERGE_BRK && (r_shift == 8'hF0));
    assign w_word = {(MERGE_BRK ? r_brk_pend : 1'b0), r_shift};

    // Shift register, bit counter, timeout counter and break flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_par        <= 1'b0;
            r_tmo_cnt    <= '0;
            r_brk_pend   <= 1'b0;
            r_busy       <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_busy       <= (w_state_nxt != S_IDLE);
            r_parity_err <= w_perr;
            r_frame_err  <= w_ferr;
            if (r_state == S_IDLE || r_fall || w_tmo) r_tmo_cnt <= '0;
            else                                     r_tmo_cnt <= r_tmo_cnt + TW'(1);
            if (r_fall && !w_tmo) begin
                case (r_state)
                    S_IDLE:   r_bit_cnt <= '0;
                    S_SHIFT: begin
                        r_shift   <= {r_kdat_s2, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                    end
                    S_PARITY: r_par <= r_kdat_s2;
                    default:  ;
                endcase
            end
            if (w_perr || w_ferr)                                 r_brk_pend <= 1'b0;
            else if (w_valid && MERGE_BRK && r_shift == 8'hF0)    r_brk_pend <= 1'b1;
            else if (w_push)                                      r_brk_pend <= 1'b0;
        end
    end

    // FWFT FIFO; a push while full succeeds only alongside a pop.
    assign w_full = (r_count == CW'(DEPTH));
    assign w_pop  = rd_en && !r_empty;
    assign w_wr   = w_push && (!w_full || w_pop);

    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr, w_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= w_word;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == '0);
        end
    end

    assign dout       = r_mem[r_rd_ptr];
    assign empty      = r_empty;
    assign count      = r_count;
    assign busy       = r_busy;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: one merging instance and one raw instance
// share the PS/2 lines; expected words are hand-computed.
module tb_ps2_rx_fifo;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned FILT    = 4;
    localparam int unsigned TIMEOUT = 256;
    localparam int unsigned CW      = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset, kclk, kdata, rd_en, rd_en_raw;
    logic [8:0]    dout, dout_raw;
    logic          empty, empty_raw, busy, busy_raw;
    logic [CW-1:0] count, count_raw;
    logic          parity_err, frame_err, overflow;
    logic          perr_raw, ferr_raw, ovf_raw;

    int n_checks = 0;
    int n_errors = 0;

    logic          s_empty_pre, s_empty, s_perr, s_ferr, s_perr2, s_ferr2;
    logic [CW-1:0] s_count;
    logic [8:0]    s_dout;

    always #5 clk = ~clk;

    ps2_rx_fifo #(.DEPTH(DEPTH), .FILT(FILT), .TIMEOUT(TIMEOUT), .MERGE_BRK(1'b1)) u_dut (
        .clk(clk), .reset(reset), .kclk(kclk), .kdata(kdata), .rd_en(rd_en),
        .dout(dout), .empty(empty), .count(count), .busy(busy),
        .parity_err(parity_err), .frame_err(frame_err), .overflow(overflow)
    );

    ps2_rx_fifo #(.DEPTH(DEPTH), .FILT(FILT), .TIMEOUT(TIMEOUT), .MERGE_BRK(1'b0)) u_raw (
        .clk(clk), .reset(reset), .kclk(kclk), .kdata(kdata), .rd_en(rd_en_raw),
        .dout(dout_raw), .empty(empty_raw), .count(count_raw), .busy(busy_raw),
        .parity_err(perr_raw), .frame_err(ferr_raw), .overflow(ovf_raw)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; kclk = 1'b1; kdata = 1'b1; rd_en = 1'b0; rd_en_raw = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Drives nbits of a frame; on a full frame samples outputs in cycles t and t+1, t+2.
    task automatic send_frame(input logic [7:0] code, input logic par_flip, input logic stop_bit,
                              input logic pop_at_t, input int nbits);
        logic [10:0] bits;
        bits = {stop_bit, (~^code) ^ par_flip, code, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            kdata = bits[i];
            repeat (5) @(posedge clk);
            #1 kclk = 1'b0;
            if (i == 10) begin
                repeat (6) @(posedge clk);
                #1 s_empty_pre = empty;
                if (pop_at_t) rd_en = 1'b1;
                @(posedge clk);
                #1 rd_en = 1'b0;
                s_empty = empty; s_count = count; s_dout = dout;
                s_perr = parity_err; s_ferr = frame_err;
                @(posedge clk);
                #1 s_perr2 = parity_err; s_ferr2 = frame_err;
                repeat (2) @(posedge clk);
            end else begin
                repeat (10) @(posedge clk);
            end
            #1 kclk = 1'b1;
            repeat (5) @(posedge clk);
            #1;
        end
        kdata = 1'b1;
    endtask

    task automatic pop_chk(input string tag, input logic [8:0] exp);
        check(tag, 16'(dout), 16'(exp));
        rd_en = 1'b1;
        @(posedge clk);
        #1 rd_en = 1'b0;
    endtask

    task automatic pop_raw_chk(input string tag, input logic [8:0] exp);
        check(tag, 16'(dout_raw), 16'(exp));
        rd_en_raw = 1'b1;
        @(posedge clk);
        #1 rd_en_raw = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "bench did not finish");
    end

    initial begin
        int  cyc;
        logic seen;

        do_reset();
        check("rst_dout",  16'(dout), 16'h000);
        check("rst_empty", 16'(empty), 16'd1);
        check("rst_count", 16'(count), 16'd0);
        check("rst_busy",  16'(busy), 16'd0);
        check("rst_perr",  16'(parity_err), 16'd0);
        check("rst_ferr",  16'(frame_err), 16'd0);
        check("rst_ovf",   16'(overflow), 16'd0);

        // Single frame with exact t+1 timing.
        send_frame(8'h16, 1'b0, 1'b1, 1'b0, 11);
        check("t1_empty_t",   16'(s_empty_pre), 16'd1);
        check("t1_empty_t1",  16'(s_empty), 16'd0);
        check("t1_count_t1",  16'(s_count), 16'd1);
        check("t1_dout_t1",   16'(s_dout), 16'h016);
        check("t1_perr",      16'(s_perr), 16'd0);
        check("t1_ferr",      16'(s_ferr), 16'd0);
        pop_chk("t1_pop", 9'h016);
        check("t1_empty_after", 16'(empty), 16'd1);

        // Three frames, FIFO order.
        send_frame(8'h16, 1'b0, 1'b1, 1'b0, 11);
        send_frame(8'h79, 1'b0, 1'b1, 1'b0, 11);
        send_frame(8'h55, 1'b0, 1'b1, 1'b0, 11);
        check("t2_count", 16'(count), 16'd3);
        pop_chk("t2_pop0", 9'h016);
        pop_chk("t2_pop1", 9'h079);
        pop_chk("t2_pop2", 9'h055);
        check("t2_empty", 16'(empty), 16'd1);

        // Break merge vs raw.
        do_reset();
        send_frame(8'hF0, 1'b0, 1'b1, 1'b0, 11);
        check("brk_f0_count", 16'(count), 16'd0);
        check("brk_f0_raw",   16'(count_raw), 16'd1);
        send_frame(8'h16, 1'b0, 1'b1, 1'b0, 11);
        check("brk_count",     16'(count), 16'd1);
        check("brk_count_raw", 16'(count_raw), 16'd2);
        pop_chk("brk_word", 9'h116);
        check("brk_empty", 16'(empty), 16'd1);
        pop_raw_chk("raw_w0", 9'h0F0);
        pop_raw_chk("raw_w1", 9'h016);
        check("raw_empty", 16'(empty_raw), 16'd1);

        // Parity and stop-bit errors.
        send_frame(8'h55, 1'b1, 1'b1, 1'b0, 11);
        check("perr_pulse", 16'(s_perr), 16'd1);
        check("perr_end",   16'(s_perr2), 16'd0);
        check("perr_noferr", 16'(s_ferr), 16'd0);
        check("perr_count", 16'(s_count), 16'd0);
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 11);
        check("ferr_pulse", 16'(s_ferr), 16'd1);
        check("ferr_end",   16'(s_ferr2), 16'd0);
        check("ferr_noperr", 16'(s_perr), 16'd0);
        check("ferr_count", 16'(s_count), 16'd0);

        // Timeout after start + 4 data bits.
        send_frame(8'h16, 1'b0, 1'b1, 1'b0, 5);
        check("tmo_busy_mid", 16'(busy), 16'd1);
        cyc = 0; seen = 1'b0;
        for (int i = 1; i <= 400; i++) begin
            @(posedge clk);
            #1;
            if (frame_err) begin cyc = i; seen = 1'b1; break; end
        end
        check("tmo_seen",   16'(seen), 16'd1);
        check("tmo_window", 16'(cyc >= 240 && cyc <= 256), 16'd1);
        check("tmo_busy",   16'(busy), 16'd0);
        @(posedge clk);
        #1 check("tmo_pulse_end", 16'(frame_err), 16'd0);
        send_frame(8'h16, 1'b0, 1'b1, 1'b0, 11);
        check("tmo_next_count", 16'(count), 16'd1);
        pop_chk("tmo_next_word", 9'h016);

        // Overflow with DEPTH=4.
        send_frame(8'h11, 1'b0, 1'b1, 1'b0, 11);
        send_frame(8'h22, 1'b0, 1'b1, 1'b0, 11);
        send_frame(8'h33, 1'b0, 1'b1, 1'b0, 11);
        send_frame(8'h44, 1'b0, 1'b1, 1'b0, 11);
        check("ovf_pre", 16'(overflow), 16'd0);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0, 11);
        check("ovf_count", 16'(count), 16'd4);
        check("ovf_flag",  16'(overflow), 16'd1);
        check("ovf_head",  16'(dout), 16'h011);
        send_frame(8'h66, 1'b0, 1'b1, 1'b1, 11);
        check("ovf_concurrent_count", 16'(s_count), 16'd4);
        pop_chk("ovf_pop0", 9'h022);
        pop_chk("ovf_pop1", 9'h033);
        pop_chk("ovf_pop2", 9'h044);
        pop_chk("ovf_pop3", 9'h066);
        check("ovf_empty", 16'(empty), 16'd1);

        // Reset mid-frame with data stored and overflow set.
        send_frame(8'h16, 1'b0, 1'b1, 1'b0, 11);
        send_frame(8'h79, 1'b0, 1'b1, 1'b0, 11);
        send_frame(8'h55, 1'b0, 1'b1, 1'b0, 4);
        check("mid_busy", 16'(busy), 16'd1);
        check("mid_count", 16'(count), 16'd2);
        #2 reset = 1'b1;
        #1;
        check("mrst_dout",  16'(dout), 16'h000);
        check("mrst_empty", 16'(empty), 16'd1);
        check("mrst_count", 16'(count), 16'd0);
        check("mrst_busy",  16'(busy), 16'd0);
        check("mrst_ovf",   16'(overflow), 16'd0);
        check("mrst_perr",  16'(parity_err), 16'd0);
        check("mrst_ferr",  16'(frame_err), 16'd0);
        kdata = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        send_frame(8'h16, 1'b0, 1'b1, 1'b0, 11);
        check("post_rst_count", 16'(s_count), 16'd1);
        check("post_rst_dout",  16'(s_dout), 16'h016);
        check("post_rst_ferr",  16'(s_ferr), 16'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
